ipb_reg_slave: RTL and testbench



---
 rtl/ipb_reg_slave.sv | 152 +++++++++++++++
 tb/tb_ipb_reg_slave.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/ipb_reg_slave.sv
// Register-bank bus slave: NREGS R/W control registers and NSTAT read-only status
// words behind a word-address map, with programmable response latency and error replies.
module ipb_reg_slave #(
  parameter int DWIDTH  = 32,
  parameter int AWIDTH  = 32,
  parameter int NREGS   = 8,
  parameter int NSTAT   = 4,
  parameter int LATENCY = 1,
  localparam int SW     = (NSTAT > 0) ? NSTAT : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    strobe,
  input  logic                    write,
  input  logic [AWIDTH-1:0]       addr,
  input  logic [DWIDTH-1:0]       wdata,
  output logic                    ack,
  output logic                    error,
  output logic [DWIDTH-1:0]       rdata,
  output logic [NREGS*DWIDTH-1:0] ctrl,
  output logic [NREGS-1:0]        ctrl_wr,
  input  logic [SW*DWIDTH-1:0]    status
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP, DONE} state_t;

  localparam logic [3:0] LAT = 4'(LATENCY);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                go_resp;
  logic [AWIDTH-1:0]   addr_q;
  logic [DWIDTH-1:0]   wdata_q;
  logic                write_q;
  logic [DWIDTH-1:0]   ctrl_q [NREGS];
  logic                ack_q, ack_d, err_q, err_d;
  logic [DWIDTH-1:0]   rdata_q, rdata_d;
  logic [NREGS-1:0]    ctrl_wr_q, ctrl_wr_d;

  logic [AWIDTH-1:0]   sel_addr;
  logic [DWIDTH-1:0]   sel_wdata;
  logic                sel_write;
  logic                hit_ctrl, hit_stat, legal;
  logic [DWIDTH-1:0]   rd_val;
  logic [NREGS-1:0]    wr_onehot;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    go_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (strobe) begin
          cnt_d = LAT;
          if (LATENCY == 0) begin
            state_d = RESP;
            go_resp = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      // An expired counter wins over a strobe drop on the same edge.
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          go_resp = 1'b1;
        end else if (!strobe) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = DONE;
      DONE:    if (!strobe) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With zero latency the response is built from the live bus on the accepting edge.
  always_comb begin
    sel_addr  = (state_q == IDLE) ? addr  : addr_q;
    sel_wdata = (state_q == IDLE) ? wdata : wdata_q;
    sel_write = (state_q == IDLE) ? write : write_q;
  end

  always_comb begin
    hit_ctrl  = 1'b0;
    hit_stat  = 1'b0;
    rd_val    = '0;
    wr_onehot = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (sel_addr == AWIDTH'(i)) begin
        hit_ctrl     = 1'b1;
        rd_val       = ctrl_q[i];
        wr_onehot[i] = 1'b1;
      end
    end
    for (int j = 0; j < NSTAT; j++) begin
      if (sel_addr == AWIDTH'(NREGS + j)) begin
        hit_stat = 1'b1;
        rd_val   = status[j*DWIDTH +: DWIDTH];
      end
    end
    legal     = hit_ctrl | (hit_stat & ~sel_write);
    ack_d     = go_resp & legal;
    err_d     = go_resp & ~legal;
    rdata_d   = (go_resp & legal & ~sel_write) ? rd_val : '0;
    ctrl_wr_d = (go_resp & hit_ctrl & sel_write) ? wr_onehot : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      ctrl_wr_q <= '0;
      for (int i = 0; i < NREGS; i++) ctrl_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      ctrl_wr_q <= ctrl_wr_d;
      for (int i = 0; i < NREGS; i++) begin
        if (ctrl_wr_d[i]) ctrl_q[i] <= sel_wdata;
      end
    end
  end

  // Captured request fields carry no reset; they are only read after acceptance.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && strobe) begin
      addr_q  <= addr;
      wdata_q <= wdata;
      write_q <= write;
    end
  end

  always_comb begin
    for (int i = 0; i < NREGS; i++) ctrl[i*DWIDTH +: DWIDTH] = ctrl_q[i];
  end

  assign ack     = ack_q;
  assign error   = err_q;
  assign rdata   = rdata_q;
  assign ctrl_wr = ctrl_wr_q;

endmodule

// File: tb/tb_ipb_reg_slave.sv
// Directed bench for ipb_reg_slave: latency, register map, errors, held strobe,
// abort and asynchronous reset in the middle of a transaction.
module tb_ipb_reg_slave;
  localparam int DW = 32, AW = 32, NR = 8, NS = 4, LAT = 2;

  logic             clk = 1'b0, rst_n = 1'b0, strobe = 1'b0, write = 1'b0;
  logic [AW-1:0]    addr = '0;
  logic [DW-1:0]    wdata = '0;
  logic             ack, error;
  logic [DW-1:0]    rdata;
  logic [NR*DW-1:0] ctrl, snap;
  logic [NR-1:0]    ctrl_wr;
  logic [NS*DW-1:0] status = '0;

  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  ipb_reg_slave #(.DWIDTH(DW), .AWIDTH(AW), .NREGS(NR), .NSTAT(NS), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .strobe(strobe), .write(write), .addr(addr),
    .wdata(wdata), .ack(ack), .error(error), .rdata(rdata), .ctrl(ctrl),
    .ctrl_wr(ctrl_wr), .status(status)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Raise strobe, then scramble addr/wdata after acceptance; k counts edges after E0.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       output int k, output logic got_ack, output logic got_err,
                       output logic [31:0] rd, output logic [7:0] wr);
    @(negedge clk);
    strobe = 1'b1; write = w; addr = a; wdata = d;
    @(posedge clk);
    #1 addr = ~a; wdata = ~d;
    k = -1; got_ack = 1'b0; got_err = 1'b0; rd = '0; wr = '0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (ack || error) begin
        k = i; got_ack = ack; got_err = error; rd = rdata; wr = ctrl_wr;
        break;
      end
    end
  endtask

  task automatic finish_xfer(input string tag);
    @(negedge clk) strobe = 1'b0;
    @(posedge clk); #1;
    check({tag, "_pulse"}, {ack, error, ctrl_wr, |rdata}, '0);
    @(posedge clk);
  endtask

  task automatic do_xfer(input string tag, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic exp_ack,
                         input logic [31:0] exp_rd, input logic [7:0] exp_wr);
    int k; logic ga, ge; logic [31:0] rd; logic [7:0] wr;
    issue(w, a, d, k, ga, ge, rd, wr);
    check({tag, "_lat"}, 64'(k), 64'(LAT + 1));
    check({tag, "_ack"}, ga, exp_ack);
    check({tag, "_err"}, ge, !exp_ack);
    check({tag, "_rdata"}, rd, exp_rd);
    check({tag, "_ctrlwr"}, wr, exp_wr);
    finish_xfer(tag);
  endtask

  task automatic quiet_window(input string tag);
    int cnt = 0;
    repeat (6) begin
      @(posedge clk); #1;
      cnt += int'(ack | error);
    end
    check(tag, 64'(cnt), 0);
  endtask

  initial begin
    int k; logic ga, ge; logic [31:0] rd; logic [7:0] wr; int cnt;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", ack, 0);
    check("rst_err", error, 0);
    check("rst_rdata", rdata, 0);
    check("rst_ctrlwr", ctrl_wr, 0);
    check("rst_ctrl", |ctrl, 0);
    @(negedge clk) rst_n = 1'b1;

    do_xfer("wr3", 1'b1, 32'd3, 32'hDEADBEEF, 1'b1, 32'h0, 8'h08);
    check("ctrl3", ctrl[3*DW +: DW], 32'hDEADBEEF);
    do_xfer("rd3", 1'b0, 32'd3, 32'h0, 1'b1, 32'hDEADBEEF, 8'h00);

    status[1*DW +: DW] = 32'h12345678;
    status[3*DW +: DW] = 32'hA5A50F0F;
    do_xfer("st1", 1'b0, 32'd9, 32'h0, 1'b1, 32'h12345678, 8'h00);
    do_xfer("st3", 1'b0, 32'd11, 32'h0, 1'b1, 32'hA5A50F0F, 8'h00);

    snap = ctrl;
    do_xfer("wr10", 1'b1, 32'd10, 32'hCAFEF00D, 1'b0, 32'h0, 8'h00);
    check("wr10_ctrl", ctrl, snap);
    do_xfer("rd12", 1'b0, 32'd12, 32'h0, 1'b0, 32'h0, 8'h00);
    do_xfer("rdhi", 1'b0, 32'h80000001, 32'h0, 1'b0, 32'h0, 8'h00);
    do_xfer("wr7", 1'b1, 32'd7, 32'h0BADF00D, 1'b1, 32'h0, 8'h80);
    do_xfer("rd7", 1'b0, 32'd7, 32'h0, 1'b1, 32'h0BADF00D, 8'h00);

    // Held strobe: only one response, then one low edge re-arms the slave.
    issue(1'b1, 32'd1, 32'h00000055, k, ga, ge, rd, wr);
    check("held_lat", 64'(k), 64'(LAT + 1));
    check("held_ack", ga, 1);
    check("held_ctrlwr", wr, 8'h02);
    quiet_window("held_extra");
    @(negedge clk) strobe = 1'b0;
    @(posedge clk);
    do_xfer("rd1", 1'b0, 32'd1, 32'h0, 1'b1, 32'h00000055, 8'h00);

    // Abort one cycle after acceptance leaves ctrl[0] untouched.
    do_xfer("wr0", 1'b1, 32'd0, 32'h00001111, 1'b1, 32'h0, 8'h01);
    @(negedge clk);
    strobe = 1'b1; write = 1'b1; addr = 32'd0; wdata = 32'h0000AAAA;
    @(posedge clk);
    @(negedge clk) strobe = 1'b0;
    quiet_window("abort_resp");
    check("abort_ctrl0", ctrl[0 +: DW], 32'h00001111);
    do_xfer("rd0", 1'b0, 32'd0, 32'h0, 1'b1, 32'h00001111, 8'h00);

    // Asynchronous reset while the write sits in WAIT.
    @(negedge clk);
    strobe = 1'b1; write = 1'b1; addr = 32'd3; wdata = 32'h00000077;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ack", ack, 0);
    check("mid_rst_err", error, 0);
    check("mid_rst_rdata", rdata, 0);
    check("mid_rst_ctrl", |ctrl, 0);
    @(negedge clk) strobe = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    quiet_window("post_rst_quiet");
    do_xfer("rd3b", 1'b0, 32'd3, 32'h0, 1'b1, 32'h0, 8'h00);

    cnt = n_bad;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
